// File: rtl/combo_code_sender.sv
// Serializes a latched code MSB-first as one-hot zero/one key strobes for a
// combination lock, each strobe followed by a fixed idle gap.
module combo_code_sender #(
  parameter int MAX_LEN = 8,
  parameter int PULSE   = 1,
  parameter int GAP     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [MAX_LEN-1:0]           code,
  input  logic [$clog2(MAX_LEN+1)-1:0] len,
  output logic                         zero,
  output logic                         one,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(MAX_LEN+1)-1:0] idx,
  output logic [1:0]                   dbg_state
);

  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int CMAX = (PULSE > GAP) ? PULSE : GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [MAX_LEN-1:0] sr;
  logic [CW-1:0]      cnt;
  logic [LW-1:0]      len_q;

  logic [LW-1:0]      len_c;
  logic [LW-1:0]      shamt;
  logic [MAX_LEN-1:0] aligned;
  logic [MAX_LEN-1:0] sr_next;
  logic [LW-1:0]      idx_nx;

  // Left-align the code so the first symbol to send always sits at the MSB.
  assign len_c     = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
  assign shamt     = LW'(MAX_LEN) - len_c;
  assign aligned   = code << shamt;
  assign sr_next   = sr << 1;
  assign idx_nx    = idx + 1'b1;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sr    <= '0;
      cnt   <= '0;
      len_q <= '0;
      idx   <= '0;
      zero  <= 1'b0;
      one   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr    <= aligned;
            len_q <= len_c;
            idx   <= '0;
            if (len_c != '0) begin
              state <= S_PULSE;
              busy  <= 1'b1;
              cnt   <= CW'(PULSE - 1);
              zero  <= ~aligned[MAX_LEN-1];
              one   <= aligned[MAX_LEN-1];
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_PULSE: begin
          if (abort) begin
            state <= S_IDLE;
            zero  <= 1'b0;
            one   <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state <= S_GAP;
            zero  <= 1'b0;
            one   <= 1'b0;
            cnt   <= CW'(GAP - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_GAP: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            idx <= idx_nx;
            sr  <= sr_next;
            if (idx_nx == len_q) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_PULSE;
              cnt   <= CW'(PULSE - 1);
              zero  <= ~sr_next[MAX_LEN-1];
              one   <= sr_next[MAX_LEN-1];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_combo_code_sender.sv
// Bench for combo_code_sender: directed lock-code sequence plus random
// start/abort/reset traffic compared cycle by cycle against a timeline model.
module tb_combo_code_sender;

  localparam int MAX_LEN = 8;
  localparam int PULSE   = 1;
  localparam int GAP     = 2;
  localparam int SPAN    = PULSE + GAP;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] code;
  logic [3:0] len;
  logic       zero;
  logic       one;
  logic       busy;
  logic       done;
  logic [3:0] idx;
  logic [1:0] dbg_state;

  int n_tests;
  int n_fail;

  // Reference model: position j within the accepted code's timeline.
  bit         m_active;
  int         m_j;
  int         m_len;
  logic [7:0] m_code;
  int         m_idle_idx;

  combo_code_sender #(.MAX_LEN(MAX_LEN), .PULSE(PULSE), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .code(code), .len(len),
    .zero(zero), .one(one), .busy(busy), .done(done), .idx(idx),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Compare the current cycle, then apply next inputs and advance the model.
  task automatic step(input bit r, input bit s, input bit a,
                      input logic [7:0] c, input int l);
    int  e_busy, e_done, e_zero, e_one, e_idx, sym;
    bit  strobe;
    @(negedge clk);
    e_busy = (m_active && m_j < m_len * SPAN) ? 1 : 0;
    e_done = (m_active && m_j == m_len * SPAN) ? 1 : 0;
    strobe = (e_busy == 1) && ((m_j % SPAN) < PULSE);
    sym    = (e_busy == 1) ? int'(m_code[m_len - 1 - m_j / SPAN]) : 0;
    e_zero = (strobe && sym == 0) ? 1 : 0;
    e_one  = (strobe && sym == 1) ? 1 : 0;
    e_idx  = !m_active ? m_idle_idx : (e_done == 1 ? m_len : m_j / SPAN);
    check("zero", int'(zero), e_zero);
    check("one",  int'(one),  e_one);
    check("busy", int'(busy), e_busy);
    check("done", int'(done), e_done);
    check("idx",  int'(idx),  e_idx);

    rst = r; start = s; abort = a; code = c; len = l[3:0];
    if (r) begin
      m_active   = 1'b0;
      m_idle_idx = 0;
    end else if (m_active) begin
      if (m_j == m_len * SPAN) begin
        m_active   = 1'b0;
        m_idle_idx = m_len;
      end else if (a) begin
        m_active   = 1'b0;
        m_idle_idx = m_j / SPAN;
      end else begin
        m_j++;
      end
    end else if (s) begin
      m_active = 1'b1;
      m_j      = 0;
      m_len    = (l > MAX_LEN) ? MAX_LEN : l;
      m_code   = c;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; code = '0; len = '0;
    m_active = 1'b0; m_j = 0; m_len = 0; m_code = '0; m_idle_idx = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Unlock code 01011, with ignored starts mid-code and during DONE.
    step(0, 1, 0, 8'h0B, 5);
    for (int i = 0; i < 20; i++) step(0, (i == 2 || i == 15), 0, 8'hA5, 7);
    // len=0, then clamped len=12 of all ones.
    step(0, 1, 0, 8'hFF, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'hFF, 12);
    for (int i = 0; i < 28; i++) step(0, 0, 0, 8'h00, 3);
    // Abort on the 5th cycle, restart two cycles later.
    step(0, 1, 0, 8'h0B, 5);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'h0B, 5);
    // Reset mid-code, then resend from symbol 0.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 8'h00, 0);
    step(1, 1, 1, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'h0B, 5);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 8'h00, 0);

    // Random traffic: codes/len change every cycle to exercise the latch.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 29) == 0, 8'($urandom), int'($urandom_range(0, 15)));
    end
    step(0, 0, 0, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/combo_code_sender.md
# combo_code_sender

Clocked generator that drives a combination lock's `zero`/`one` key inputs. It serializes a latched code of up to `MAX_LEN` symbols MSB-first as one-hot key strobes, with a fixed idle gap after every symbol. It is the entry-side counterpart to the combination lock detector and is used as the stimulus and auto-entry source for that lock (e.g. sending `01011` to unlock).

## Interface
- `MAX_LEN`, default 8: maximum code length in symbols; `code` width.
- `PULSE`, default 1: cycles each strobe (`zero` or `one`) is held high; must be ≥1.
- `GAP`, default 2: cycles both strobes are low after each strobe; must be ≥1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request to send; sampled only in IDLE.
- `abort`  in  1  cancel the transmission in progress.
- `code`  in  `MAX_LEN`  symbols; `code[len-1]` is sent first, `code[0]` last; 0 → `zero`, 1 → `one`.
- `len`  in  `$clog2(MAX_LEN+1)`  number of symbols to send; values > `MAX_LEN` are clamped to `MAX_LEN`.
- `zero`  out  1  strobe for symbol 0 (registered).
- `one`  out  1  strobe for symbol 1 (registered).
- `busy`  out  1  high while a code is being sent (PULSE and GAP states).
- `done`  out  1  one-cycle pulse after the last gap of a completed code.
- `idx`  out  `$clog2(MAX_LEN+1)`  number of symbols fully sent so far in the current code.

## Operation
- States: IDLE, PULSE, GAP, DONE. All outputs are registered from state and datapath.
- Reset: state IDLE; `zero`=`one`=`busy`=`done`=0; `idx`=0; shift register and counters cleared. `rst` overrides `start` and `abort`.
- IDLE: on `start`=1, latch `code` into a shift register aligned so bit `len-1` is at the MSB. Latch the clamped length and clear `idx`.
  - If the clamped length ≥1, go to PULSE.
  - If `len`=0, go directly to DONE; no strobe is emitted.
  - Changes on `code`/`len` after the latch cycle have no effect.
- PULSE: drive the strobe for the current symbol for `PULSE` cycles. Exactly one of `zero`/`one` is high; both high is never permitted. Then go to GAP.
- GAP: `zero`=`one`=0 for `GAP` cycles.
  - On exit, increment `idx` and shift out the sent symbol.
  - If `idx` now equals the latched length, go to DONE; otherwise go to PULSE for the next symbol.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE. `start` is ignored in DONE.
- `abort`=1 in PULSE or GAP: next cycle the state is IDLE, both strobes are 0, `busy`=0, `done` stays 0, and `idx` holds its value.
  - `abort` in IDLE or DONE has no effect. DONE still completes and pulses `done`.
- `start` while `busy` is ignored; there is no queueing.

## Timing
- `start` sampled high in IDLE at edge t: first strobe is visible in cycle t+1. `busy`=1 from t+1.
- Each symbol occupies `PULSE+GAP` cycles. Symbol k (0-based) has its strobe in cycles t+1+k·(PULSE+GAP) through t+k·(PULSE+GAP)+PULSE.
- `done` is high in cycle t+1+L·(PULSE+GAP), where L is the clamped length; `busy` is low in that cycle.
- Earliest next accepted `start` is the cycle after `done`. Minimum spacing between consecutive codes is L·(PULSE+GAP)+2 cycles.
- `len`=0: `done` is high in cycle t+1, `busy` stays 0, and no strobes occur.
- `rst` asserted mid-code: outputs reach their reset values at the next edge. No `done` is produced.

## Test plan
- Defaults, `code`=8'b0000_1011, `len`=5, pulse `start` at t.
  - Strobes `zero`@t+1, `one`@t+4, `zero`@t+7, `one`@t+10, `one`@t+13.
  - `done`@t+16, `idx`=5. A connected combination lock reports `unlocked`.
- `len`=0 with `start`: `done` high only at t+1; `zero`/`one`/`busy` stay 0.
- `len`=12, `code`=8'hFF, MAX_LEN=8: exactly 8 `one` strobes are sent, `done`@t+25, and `zero` is never asserted.
- `abort` at t+5 during a 5-symbol code.
  - Strobes are 0 and `busy`=0 from t+6; no `done` follows; `idx`=1.
  - A new `start` at t+7 is accepted.
- Second `start` at t+3 mid-code, and `start` during the DONE cycle: both ignored. The first code completes unchanged and no extra strobes appear.
- `rst` at t+8 mid-code: all outputs are 0 from t+9. `start` at t+10 sends the full code from symbol 0.
